// File: rtl/test_seq_pkg.sv
// Shared types and LFSR helpers for the stimulus sequencer.
package test_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Feedback taps at bits 15, 13, 12 and 10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/test_seq_fifo.sv
// Scoreboard FIFO: synchronous, power-of-two depth, same-cycle push/pop
// allowed even when full.
module test_seq_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == FULL_CNT);
  assign count = cnt_q;
  assign dout  = mem_q[rd_q];

  // Qualify requests and compute next pointers/occupancy.
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (clr) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
      cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage array; contents are don't-care while unoccupied.
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/test_seq.sv
// Self-checking stimulus sequencer: issues an LFSR word stream, scores
// in-order responses against a scoreboard FIFO, reports counts/timeout/pass.
module test_seq
  import test_seq_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned NUM_TXN  = 16,
  parameter int unsigned SB_DEPTH = 8,
  parameter int unsigned TIMEOUT  = 1024,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              stim_valid,
  input  logic              stim_ready,
  output logic [DATA_W-1:0] stim_data,
  input  logic              rsp_valid,
  input  logic [DATA_W-1:0] rsp_data,
  output logic [15:0]       txn_count,
  output logic [15:0]       err_count,
  output logic              timeout,
  output logic              done,
  output logic              pass
);

  localparam int unsigned CW = $clog2(SB_DEPTH) + 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [15:0] NUM = 16'(NUM_TXN);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [15:0]   issued_q, issued_d;
  logic [15:0]   txn_q, txn_d;
  logic [15:0]   err_q, err_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          timeout_q, timeout_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;

  logic              sb_clr, sb_push, sb_pop, sb_full, sb_empty;
  logic [DATA_W-1:0] sb_head;
  logic [CW-1:0]     sb_count, occ_next;

  logic              active, xfer, rsp_act, bypass, matched, hit;
  logic [DATA_W-1:0] expect_word;

  assign stim_data = lfsr_q[DATA_W-1:0];
  assign txn_count = txn_q;
  assign err_count = err_q;
  assign timeout   = timeout_q;
  assign done      = done_q;
  assign pass      = pass_q;

  test_seq_fifo #(
    .W     (DATA_W),
    .DEPTH (SB_DEPTH)
  ) u_sb (
    .clk   (clk),
    .rst   (rst),
    .clr   (sb_clr),
    .push  (sb_push),
    .pop   (sb_pop),
    .din   (stim_data),
    .dout  (sb_head),
    .full  (sb_full),
    .empty (sb_empty),
    .count (sb_count)
  );

  // Handshake decode, scoring, idle timer and FSM next state.
  always_comb begin
    active     = (state_q == RUN) || (state_q == DRAIN);
    stim_valid = (state_q == RUN) && (issued_q < NUM) && !sb_full;
    xfer       = stim_valid && stim_ready;
    rsp_act    = active && rsp_valid;
    // Zero-latency loopback: a response arriving with an empty scoreboard
    // in the same cycle as a transfer is scored directly against the word
    // being issued, and that word never enters the FIFO.
    bypass      = rsp_act && sb_empty && xfer;
    sb_push     = xfer && !bypass;
    sb_pop      = rsp_act && !sb_empty;
    matched     = sb_pop || bypass;
    expect_word = sb_empty ? stim_data : sb_head;
    occ_next    = sb_count + CW'(sb_push) - CW'(sb_pop);
    hit         = active && !rsp_valid && (sb_count != '0) && (timer_q == TIMER_LAST);

    sb_clr    = 1'b0;
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    issued_d  = issued_q;
    txn_d     = txn_q;
    err_d     = err_q;
    timer_d   = timer_q;
    timeout_d = timeout_q;
    done_d    = done_q;
    pass_d    = pass_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = RUN;
          sb_clr    = 1'b1;
          lfsr_d    = SEED;
          issued_d  = '0;
          txn_d     = '0;
          err_d     = '0;
          timer_d   = '0;
          timeout_d = 1'b0;
          done_d    = 1'b0;
          pass_d    = 1'b0;
        end
      end
      RUN, DRAIN: begin
        if (xfer) begin
          issued_d = issued_q + 16'd1;
          lfsr_d   = lfsr_next(lfsr_q);
        end
        if (rsp_act) begin
          timer_d = '0;
          if (matched) txn_d = txn_q + 16'd1;
          if ((!matched || (rsp_data != expect_word)) && (err_q != 16'hFFFF))
            err_d = err_q + 16'd1;
        end else if (sb_count != '0) begin
          timer_d = timer_q + 1'b1;
        end
        // Finish on the same edge as the final pop so done/pass line up
        // with the last counter update.
        if (hit) begin
          state_d   = DONE;
          timeout_d = 1'b1;
          done_d    = 1'b1;
          pass_d    = 1'b0;
        end else if (issued_d == NUM) begin
          if (occ_next == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
            pass_d  = (err_d == '0) && (txn_d == NUM);
          end else begin
            state_d = DRAIN;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, LFSR, counters and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      lfsr_q    <= SEED;
      issued_q  <= '0;
      txn_q     <= '0;
      err_q     <= '0;
      timer_q   <= '0;
      timeout_q <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      issued_q  <= issued_d;
      txn_q     <= txn_d;
      err_q     <= err_d;
      timer_q   <= timer_d;
      timeout_q <= timeout_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
    end
  end

endmodule

// File: tb/tb_test_seq.sv
// Bench for test_seq: an emulated DUT loops stimulus back under several
// latency/backpressure modes while a transaction-level model predicts outputs.
module tb_test_seq;

  localparam int DW    = 8;
  localparam int NT    = 16;
  localparam int DEPTH = 8;
  localparam int TO    = 32;

  localparam int M_LAT1  = 0;
  localparam int M_HOLD8 = 1;
  localparam int M_ZERO  = 2;
  localparam int M_STOP4 = 3;
  localparam int M_RAND  = 4;

  logic          clk = 1'b0;
  logic          rst, start, stim_valid, stim_ready, rsp_valid;
  logic [DW-1:0] stim_data, rsp_data;
  logic [15:0]   txn_count, err_count;
  logic          timeout, done, pass;

  always #5 clk = ~clk;

  test_seq #(
    .DATA_W   (DW),
    .NUM_TXN  (NT),
    .SB_DEPTH (DEPTH),
    .TIMEOUT  (TO),
    .SEED     (16'hACE1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stim_valid (stim_valid),
    .stim_ready (stim_ready),
    .stim_data  (stim_data),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .txn_count  (txn_count),
    .err_count  (err_count),
    .timeout    (timeout),
    .done       (done),
    .pass       (pass)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Transaction-level model of the sequencer.
  logic [15:0]   m_lfsr;
  int            m_issued, m_txn, m_err, m_idle;
  bit            m_active, m_done, m_to, m_pass;
  logic [DW-1:0] m_sb[$];
  logic [DW-1:0] emu_q[$];
  logic [DW-1:0] got_q[$];

  function automatic logic [15:0] ref_step(input logic [15:0] s);
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    return {s[14:0], fb};
  endfunction

  function automatic bit model_valid();
    return m_active && (m_issued < NT) && (m_sb.size() < DEPTH);
  endfunction

  task automatic model_clear();
    m_active = 0; m_done = 0; m_to = 0; m_pass = 0;
    m_txn = 0; m_err = 0; m_idle = 0; m_issued = 0;
    m_lfsr = 16'hACE1;
    m_sb.delete();
    emu_q.delete();
  endtask

  task automatic check_outputs();
    bit ev;
    ev = model_valid();
    check("stim_valid", 32'(stim_valid), 32'(ev));
    if (ev) check("stim_data", 32'(stim_data), 32'(m_lfsr[DW-1:0]));
    check("txn_count", 32'(txn_count), 32'(m_txn));
    check("err_count", 32'(err_count), 32'(m_err));
    check("done", 32'(done), 32'(m_done));
    check("timeout", 32'(timeout), 32'(m_to));
    check("pass", 32'(pass), 32'(m_pass));
  endtask

  task automatic run_test(input string name, input int mode, input int corrupt_n,
                          input int stall_at, input int glitch_at, input int limit,
                          input bit expect_finish, input int exp_txn, input int exp_err,
                          input bit exp_pass, input bit exp_to);
    int            cyc, rsp_n;
    bit            ev, xfer, bypass, hold_open, prev_hold;
    logic [DW-1:0] w, head, prev_data;
    // Start cycle: outputs still reflect the previous run.
    @(negedge clk);
    check_outputs();
    start = 1'b1; stim_ready = 1'b0; rsp_valid = 1'b0;
    model_clear();
    m_active = 1;
    got_q.delete();
    rsp_n = 0; hold_open = 0; prev_hold = 0; prev_data = '0;
    cyc = 0;
    @(negedge clk);
    start = 1'b0;
    while (m_active && cyc < limit) begin
      check_outputs();
      if (prev_hold) check({name, "_hold"}, 32'(stim_data), 32'(prev_data));
      ev = model_valid();
      w  = m_lfsr[DW-1:0];
      start = (cyc == glitch_at);
      if (mode == M_RAND) stim_ready = 1'($urandom_range(1, 0));
      else stim_ready = !(stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 5);
      // Emulated DUT response.
      case (mode)
        M_HOLD8: begin
          if (emu_q.size() >= 8) hold_open = 1;
          rsp_valid = hold_open && (emu_q.size() > 0);
        end
        M_ZERO:  rsp_valid = stim_valid && stim_ready;
        M_STOP4: rsp_valid = (emu_q.size() > 0) && (rsp_n < 4);
        M_RAND:  rsp_valid = (emu_q.size() > 0) && 1'($urandom_range(1, 0));
        default: rsp_valid = (emu_q.size() > 0);
      endcase
      if (mode == M_ZERO) rsp_data = stim_data;
      else if (rsp_valid) rsp_data = emu_q.pop_front();
      else rsp_data = DW'($urandom);
      if (rsp_valid) begin
        rsp_n++;
        if (rsp_n == corrupt_n) rsp_data[0] = ~rsp_data[0];
      end
      if (stim_valid && stim_ready) begin
        got_q.push_back(stim_data);
        if (mode != M_ZERO) emu_q.push_back(stim_data);
      end
      // Model update for the coming edge.
      xfer = ev && stim_ready;
      bypass = 0;
      if (rsp_valid) begin
        m_idle = 0;
        if (m_sb.size() > 0) begin
          head = m_sb.pop_front();
          m_txn++;
          if (rsp_data != head) m_err++;
        end else if (xfer) begin
          bypass = 1;
          m_txn++;
          if (rsp_data != w) m_err++;
        end else begin
          m_err++;
        end
      end else if (m_sb.size() > 0) begin
        m_idle++;
      end
      if (xfer) begin
        if (!bypass) m_sb.push_back(w);
        m_issued++;
        m_lfsr = ref_step(m_lfsr);
      end
      if (m_idle >= TO) begin
        m_active = 0; m_done = 1; m_to = 1; m_pass = 0;
      end else if (m_issued == NT && m_sb.size() == 0) begin
        m_active = 0; m_done = 1;
        m_pass = (m_err == 0) && (m_txn == NT);
      end
      prev_hold = ev && !stim_ready;
      prev_data = w;
      cyc++;
      @(negedge clk);
    end
    start = 1'b0; stim_ready = 1'b0; rsp_valid = 1'b0;
    check_outputs();
    if (expect_finish) begin
      check({name, "_finished"}, 32'(done), 32'd1);
      check({name, "_txn"}, 32'(txn_count), 32'(exp_txn));
      check({name, "_err"}, 32'(err_count), 32'(exp_err));
      check({name, "_pass"}, 32'(pass), 32'(exp_pass));
      check({name, "_timeout"}, 32'(timeout), 32'(exp_to));
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; stim_ready = 1'b0; rsp_valid = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_outputs();
    check("reset_stim_data", 32'(stim_data), 32'h0000_00E1);
  endtask

  task automatic idle_cycles(input int n, input bit rv);
    for (int i = 0; i < n; i++) begin
      rsp_valid = rv;
      rsp_data  = DW'($urandom);
      stim_ready = 1'b1;
      @(negedge clk);
      check_outputs();
    end
    rsp_valid = 1'b0;
    stim_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stim_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
    model_clear();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_outputs();
    check("reset_stim_data", 32'(stim_data), 32'h0000_00E1);

    // 1-cycle loopback.
    run_test("lat1", M_LAT1, 0, -1, -1, 400, 1, 16, 0, 1, 0);
    if (got_q.size() >= 2) begin
      check("word0", 32'(got_q[0]), 32'h0000_00E1);
      check("word1", 32'(got_q[1]), 32'h0000_00C3);
    end else begin
      check("word_count", 32'(got_q.size()), 32'd2);
    end

    // Responses in DONE must be ignored.
    idle_cycles(3, 1'b1);

    // Third response corrupted.
    run_test("corrupt3", M_LAT1, 3, -1, -1, 400, 1, 16, 1, 0, 0);

    // Five-cycle backpressure stall, plus a start pulse mid-run that must be ignored.
    run_test("stall", M_LAT1, 0, 6, 3, 400, 1, 16, 0, 1, 0);
    check("stall_words", 32'(got_q.size()), 32'd16);

    // Responses withheld until the scoreboard is full.
    run_test("hold8", M_HOLD8, 0, -1, -1, 400, 1, 16, 0, 1, 0);

    // Zero-latency loopback.
    run_test("zero", M_ZERO, 0, -1, -1, 400, 1, 16, 0, 1, 0);

    // DUT goes silent after four responses.
    run_test("stop4", M_STOP4, 0, -1, -1, 400, 1, 4, 0, 0, 1);

    // Reset mid-run, then a full run with the same sequence.
    run_test("pre_reset", M_LAT1, 0, -1, -1, 6, 0, 0, 0, 0, 0);
    apply_reset();
    run_test("post_reset", M_LAT1, 0, -1, -1, 400, 1, 16, 0, 1, 0);
    if (got_q.size() >= 1) check("post_reset_word0", 32'(got_q[0]), 32'h0000_00E1);

    // Randomized backpressure and response timing.
    for (int r = 0; r < 3; r++) begin
      run_test("rand", M_RAND, 0, -1, -1, 600, 1, 16, 0, 1, 0);
    end
    run_test("rand_corrupt", M_RAND, 7, -1, -1, 600, 1, 16, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/test_seq.md
# test_seq

Synthesizable self-checking stimulus sequencer that drives a loopback transaction stream into a DUT and scores the returned responses in order. It sits beside the DUT inside the top-level bench and shares the bench clock and reset. It reports transaction count, mismatch count, timeout and a final pass flag.

## Interface
- DATA_W, 8: stimulus/response data width (1..16).
- NUM_TXN, 16: transactions issued per run (1..65535).
- SB_DEPTH, 8: scoreboard FIFO depth (power of two, ≥2).
- TIMEOUT, 1024: idle cycles with outstanding responses before abort.
- SEED, 16'hACE1: LFSR reset value (nonzero).
- clk  in  1  bench clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; launches a run from IDLE or DONE.
- stim_valid  out  1  stimulus word valid.
- stim_ready  in  1  DUT accepts stimulus.
- stim_data  out  DATA_W  stimulus payload.
- rsp_valid  in  1  DUT response valid (no backpressure).
- rsp_data  in  DATA_W  DUT response payload.
- txn_count  out  16  responses received this run.
- err_count  out  16  mismatching responses, saturating at 16'hFFFF.
- timeout  out  1  run aborted by timeout.
- done  out  1  run finished.
- pass  out  1  done && err_count==0 && !timeout && txn_count==NUM_TXN.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE --start--> RUN; DONE --start--> RUN. On start: counters, scoreboard, idle timer cleared; LFSR reloaded to SEED; done/timeout/pass cleared.
- RUN: stim_valid=1 when issued<NUM_TXN and scoreboard not full. A transfer occurs when stim_valid && stim_ready: stim_data is pushed into the scoreboard, issued increments, LFSR advances.
- RUN -> DRAIN when issued==NUM_TXN. DRAIN -> DONE when scoreboard empty.
- LFSR: 16-bit, next = {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}. stim_data = lfsr[DATA_W-1:0].
- Response: on rsp_valid, pop scoreboard head, txn_count++, err_count++ if rsp_data != head. If rsp_valid arrives with the scoreboard empty, err_count++ and txn_count is unchanged.
- Simultaneous push and pop in one cycle is legal; occupancy is unchanged, including when full. stim_valid is computed from the pre-pop occupancy.
- Idle timer: counts cycles in RUN/DRAIN with occupancy>0 and no rsp_valid. It clears on any rsp_valid. Reaching TIMEOUT sets timeout=1 and forces DONE.
- start outside IDLE/DONE is ignored.
- rsp_valid in IDLE/DONE is ignored.

## Timing
- Reset values: stim_valid=0, stim_data=SEED[DATA_W-1:0], txn_count=0, err_count=0, timeout=0, done=0, pass=0; state=IDLE.
- Reset mid-run aborts immediately to IDLE with the scoreboard emptied.
- stim_valid rises the cycle after start is sampled. Stimulus can then be accepted every cycle.
- stim_data holds stable while stim_valid && !stim_ready.
- Response compare and counter update are registered, visible one cycle after rsp_valid.
- done and pass are registered. They assert one cycle after the final pop (or after the timeout hit) and hold until start or rst.
- Zero-latency loopback (rsp_valid = transfer in the same cycle) must be supported.

## Structure
- Package test_seq_pkg: state enum, LFSR tap constant, LFSR next-state function.
- Sub-module test_seq_fifo: synchronous FIFO with full/empty flags and same-cycle push/pop, instantiated as the scoreboard.
- Top holds the FSM, LFSR, counters and idle timer.

## Test plan
- Loopback, DUT returns stimulus with 1-cycle latency, NUM_TXN=16 -> done, pass=1, txn_count=16, err_count=0. First two words are 8'hE1, then 8'hC3.
- Response corrupted (bit0 flipped) on the 3rd response -> err_count=1, pass=0, txn_count=16.
- stim_ready low for 5 cycles mid-run -> stim_data held stable. No duplicate or lost words; pass=1.
- DUT delays responses until 8 words are outstanding (SB_DEPTH=8) -> stim_valid drops at full. Resumes on the first pop; pass=1.
- DUT stops responding after 4 words, TIMEOUT=32 -> timeout=1 and done 32 cycles after the last response; pass=0.
- rst asserted mid-run, then start -> all outputs at reset values, and the second run passes with the same data sequence.
